matcher_stream_scan: RTL and testbench

//  Multi-key streaming byte-pattern matcher, successor to the single-key matcher datapath.

---
 rtl/matcher_stream_scan.sv | 196 +++++++++++++++++++
 tb/tb_matcher_stream_scan.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matcher_stream_scan.sv
// matcher_stream_scan
//   Multi-key streaming byte-pattern matcher. Every accepted beat, together with
//   the last KEY_BYTES-1 bytes of the previous beat of the same stream, is
//   compared against NUM_KEYS run-time keys at every byte position. Hits are
//   latched and drained one per cycle, lowest position first (then lowest key
//   slot), into a small result FIFO read with a valid/ready handshake.
//
// Ports
//   fclk, areset                  clock, asynchronous active-high reset
//   in_data/in_valid/in_last      stream beat (byte 0 earliest), last-of-stream flag
//   in_ready                      beat accepted on in_valid && in_ready
//   key_wr_en/key_wr_idx/key_wr_data  load and enable one key slot
//   key_clr                       disable all key slots (beats key_wr_en)
//   first_only                    report only the first hit of each stream
//   res_valid/res_ready           result FIFO head handshake
//   res_key_idx/res_offset        matching slot and stream byte offset of the head
//   match_count                   saturating count of results pushed
module matcher_stream_scan #(
    parameter int BEAT_WIDTH = 512,
    parameter int KEY_WIDTH  = 64,
    parameter int NUM_KEYS   = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int KIW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                  fclk,
    input  logic                  areset,
    input  logic [BEAT_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  key_wr_en,
    input  logic [KIW-1:0]        key_wr_idx,
    input  logic [KEY_WIDTH-1:0]  key_wr_data,
    input  logic                  key_clr,
    input  logic                  first_only,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [KIW-1:0]        res_key_idx,
    output logic [31:0]           res_offset,
    output logic [31:0]           match_count
);
    localparam int BEAT_BYTES = BEAT_WIDTH / 8;
    localparam int KEY_BYTES  = KEY_WIDTH / 8;
    localparam int TAIL_BYTES = KEY_BYTES - 1;
    localparam int TW         = TAIL_BYTES * 8;
    localparam int WIN_W      = BEAT_WIDTH + TW;
    localparam int PW         = $clog2(BEAT_BYTES);
    localparam int FAW        = $clog2(FIFO_DEPTH);
    localparam int EW         = KIW + 32;

    typedef enum logic {SCAN, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [KEY_WIDTH-1:0] key_reg [NUM_KEYS];
    logic [NUM_KEYS-1:0]  key_en_reg;

    logic [TW-1:0] tail_reg;
    logic          tail_valid_reg;
    logic [31:0]   beat_base_reg;
    logic [31:0]   drain_base_reg;
    logic          drain_last_reg;
    logic          suppress_reg;
    logic [31:0]   match_count_reg;

    logic [BEAT_BYTES-1:0][NUM_KEYS-1:0] hit_now, hits_reg, hits_clr;
    logic [WIN_W-1:0] window;
    logic             accept, hit_any, push, pop;
    logic [PW-1:0]    sel_p;
    logic [KIW-1:0]   sel_k;

    logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [FAW:0]   wr_ptr_reg, rd_ptr_reg;
    logic           fifo_empty, fifo_full;
    logic [EW-1:0]  fifo_head;

    // Tail occupies the low window bytes so that window byte w lines up with
    // stream order: old tail bytes first, then the new beat.
    assign window = {in_data, tail_reg};

    genvar gi, gk;
    generate
        for (gi = 0; gi < BEAT_BYTES; gi++) begin : g_pos
            for (gk = 0; gk < NUM_KEYS; gk++) begin : g_key
                if (gi < TAIL_BYTES) begin : g_tail
                    // Positions that start in the tail only exist mid-stream.
                    assign hit_now[gi][gk] = key_en_reg[gk] && tail_valid_reg &&
                                             (window[gi*8 +: KEY_WIDTH] == key_reg[gk]);
                end else begin : g_beat
                    assign hit_now[gi][gk] = key_en_reg[gk] &&
                                             (window[gi*8 +: KEY_WIDTH] == key_reg[gk]);
                end
            end
        end
    endgenerate

    assign in_ready = (state_reg == SCAN) && !areset;
    assign accept   = in_valid && in_ready;
    assign hit_any  = (|hit_now) && !(first_only && suppress_reg);

    // Lowest position wins, then lowest key slot: scan downwards and let the
    // last assignment stand.
    always_comb begin
        sel_p = '0;
        sel_k = '0;
        for (int p = BEAT_BYTES - 1; p >= 0; p--) begin
            for (int k = NUM_KEYS - 1; k >= 0; k--) begin
                if (hits_reg[p][k]) begin
                    sel_p = PW'(p);
                    sel_k = KIW'(k);
                end
            end
        end
        hits_clr = hits_reg;
        hits_clr[sel_p][sel_k] = 1'b0;
    end

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[FAW] != rd_ptr_reg[FAW]) &&
                        (wr_ptr_reg[FAW-1:0] == rd_ptr_reg[FAW-1:0]);
    assign push       = (state_reg == DRAIN) && !fifo_full;
    assign pop        = !fifo_empty && res_ready;
    assign fifo_head  = fifo_mem[rd_ptr_reg[FAW-1:0]];

    assign res_valid   = !fifo_empty;
    assign res_key_idx = fifo_empty ? '0 : fifo_head[EW-1 -: KIW];
    assign res_offset  = fifo_empty ? '0 : fifo_head[31:0];
    assign match_count = match_count_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SCAN:  if (accept && hit_any) state_next = DRAIN;
            // In first_only mode one push ends the beat; the rest is dropped.
            DRAIN: if (push && (first_only || hits_clr == '0)) state_next = SCAN;
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge fclk or posedge areset) begin
        if (areset) begin
            state_reg       <= SCAN;
            key_en_reg      <= '0;
            tail_reg        <= '0;
            tail_valid_reg  <= 1'b0;
            beat_base_reg   <= '0;
            drain_base_reg  <= '0;
            drain_last_reg  <= 1'b0;
            suppress_reg    <= 1'b0;
            hits_reg        <= '0;
            match_count_reg <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            state_reg <= state_next;

            if (key_clr)        key_en_reg             <= '0;
            else if (key_wr_en) key_en_reg[key_wr_idx] <= 1'b1;

            if (accept) begin
                tail_reg       <= in_data[BEAT_WIDTH-1 -: TW];
                hits_reg       <= hit_now;
                drain_base_reg <= beat_base_reg;
                drain_last_reg <= in_last;
                if (in_last) begin
                    tail_valid_reg <= 1'b0;
                    beat_base_reg  <= '0;
                    suppress_reg   <= 1'b0;
                end else begin
                    tail_valid_reg <= 1'b1;
                    beat_base_reg  <= beat_base_reg + 32'(BEAT_BYTES);
                end
            end

            if (push) begin
                hits_reg   <= first_only ? '0 : hits_clr;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (match_count_reg != 32'hFFFF_FFFF)
                    match_count_reg <= match_count_reg + 32'd1;
                // A push from the stream's last beat must not mute the next stream.
                if (first_only && !drain_last_reg)
                    suppress_reg <= 1'b1;
            end

            if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Key contents and FIFO storage need no reset: enables and pointers gate them.
    always_ff @(posedge fclk) begin
        if (key_wr_en && !key_clr)
            key_reg[key_wr_idx] <= key_wr_data;
        if (push)
            fifo_mem[wr_ptr_reg[FAW-1:0]] <=
                {sel_k, drain_base_reg + 32'(sel_p) - 32'(TAIL_BYTES)};
    end
endmodule

// File: tb/tb_matcher_stream_scan.sv
module tb_matcher_stream_scan;
    localparam int BW = 512;
    localparam int KW = 64;
    localparam int NK = 4;
    localparam int BB = BW / 8;
    localparam int KB = KW / 8;

    logic          fclk = 1'b0;
    logic          areset = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          key_wr_en = 1'b0;
    logic [1:0]    key_wr_idx = '0;
    logic [KW-1:0] key_wr_data = '0;
    logic          key_clr = 1'b0;
    logic          first_only = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [1:0]    res_key_idx;
    logic [31:0]   res_offset;
    logic [31:0]   match_count;

    matcher_stream_scan #(.BEAT_WIDTH(BW), .KEY_WIDTH(KW), .NUM_KEYS(NK), .FIFO_DEPTH(8)) dut (
        .fclk(fclk), .areset(areset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .key_wr_en(key_wr_en),
        .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data), .key_clr(key_clr),
        .first_only(first_only), .res_valid(res_valid), .res_ready(res_ready),
        .res_key_idx(res_key_idx), .res_offset(res_offset), .match_count(match_count)
    );

    always #5 fclk = ~fclk;

    int checks = 0;
    int errors = 0;
    bit rand_rr = 1'b0;

    // ---------------- behavioural reference ----------------
    typedef struct { int k; int unsigned off; } res_t;
    res_t        exp_q[$];
    byte unsigned m_key [NK][KB];
    bit          m_en [NK];
    byte unsigned m_prev [BB];
    bit          m_tv = 1'b0;
    int unsigned m_base = 0;
    bit          m_sup = 1'b0;
    int unsigned m_pushes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        foreach (m_en[k]) m_en[k] = 1'b0;
        m_tv = 1'b0; m_base = 0; m_sup = 1'b0; m_pushes = 0;
    endfunction

    // Stream-order byte list: previous beat's last KB-1 bytes, then this beat.
    function automatic void model_accept(input logic [BW-1:0] d, input logic last, input logic fo);
        byte unsigned win [BB+KB-1];
        bit done = 1'b0;
        for (int w = 0; w < BB + KB - 1; w++)
            win[w] = (w < KB - 1) ? m_prev[BB - (KB - 1) + w] : d[8*(w-(KB-1)) +: 8];
        if (!(fo && m_sup)) begin
            for (int p = 0; p < BB; p++) begin
                for (int k = 0; k < NK; k++) begin
                    bit eq = m_en[k] && (m_tv || p >= KB - 1);
                    for (int j = 0; j < KB; j++)
                        if (win[p+j] != m_key[k][j]) eq = 1'b0;
                    if (eq && !done) begin
                        res_t r;
                        r.k = k;
                        r.off = m_base + p - (KB - 1);
                        exp_q.push_back(r);
                        m_pushes++;
                        if (fo) begin
                            done = 1'b1;
                            if (!last) m_sup = 1'b1;
                        end
                    end
                end
            end
        end
        for (int i = 0; i < BB; i++) m_prev[i] = d[8*i +: 8];
        if (last) begin m_tv = 1'b0; m_base = 0; m_sup = 1'b0; end
        else begin m_tv = 1'b1; m_base += BB; end
    endfunction

    // ---------------- result monitor ----------------
    always @(negedge fclk) begin
        if (!areset && res_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL res_spurious: got key %0d offset %0d expected none", res_key_idx, res_offset);
            end else begin
                check("res_key_idx", 32'(res_key_idx), 32'(exp_q[0].k));
                check("res_offset", res_offset, exp_q[0].off);
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge fclk) begin
        if (rand_rr) begin
            #1;
            if (rand_rr) res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks (start/end at posedge+1) ----------------
    task automatic write_key(input int idx, input logic [KW-1:0] v);
        key_wr_en = 1'b1; key_wr_idx = 2'(idx); key_wr_data = v;
        @(posedge fclk); #1;
        key_wr_en = 1'b0;
        for (int j = 0; j < KB; j++) m_key[idx][j] = v[8*j +: 8];
        m_en[idx] = 1'b1;
    endtask

    task automatic clear_keys();
        key_clr = 1'b1;
        @(posedge fclk); #1;
        key_clr = 1'b0;
        foreach (m_en[k]) m_en[k] = 1'b0;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input logic last);
        int t = 0;
        in_data = d; in_last = last; in_valid = 1'b1;
        @(negedge fclk);
        while (!in_ready && t < 1000) begin @(negedge fclk); t++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end else model_accept(d, last, first_only);
        @(posedge fclk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge fclk);
        while (!(exp_q.size() == 0 && in_ready && !res_valid) && t < 2000) begin
            @(negedge fclk); t++;
        end
        if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge fclk); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge fclk); #1; end
    endtask

    function automatic logic [BW-1:0] place(input logic [BW-1:0] d, input int off, input logic [KW-1:0] k);
        logic [BW-1:0] r = d;
        for (int j = 0; j < KB; j++)
            if (off + j < BB) r[8*(off+j) +: 8] = k[8*j +: 8];
        return r;
    endfunction

    function automatic logic [KW-1:0] rand_key();
        logic [KW-1:0] v;
        for (int j = 0; j < KB; j++) v[8*j +: 8] = 8'($urandom_range(0, 1));
        return v;
    endfunction

    localparam logic [KW-1:0] KEY_A = 64'h0807060504030201;
    localparam logic [KW-1:0] KEY_B = 64'h1817161514131211;

    initial begin
        logic [BW-1:0] d;
        logic [BW-1:0] d10;
        int n;

        #2 areset = 1'b1;
        model_reset();
        @(negedge fclk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_key_idx", 32'(res_key_idx), 0);
        check("rst_res_offset", res_offset, 0);
        check("rst_match_count", match_count, 0);
        @(posedge fclk); #1 areset = 1'b0;
        cycles(1);
        check("post_rst_in_ready", 32'(in_ready), 1);

        // Single hit, latency and offset.
        write_key(0, KEY_A);
        send_beat(place('0, 5, KEY_A), 1'b1);
        check("t1_res_valid_at_accept", 32'(res_valid), 0);
        cycles(1);
        check("t1_res_valid", 32'(res_valid), 1);
        check("t1_res_offset", res_offset, 5);
        check("t1_res_key_idx", 32'(res_key_idx), 0);
        check("t1_match_count", match_count, 1);
        wait_idle();

        // Match straddling two beats.
        d = '0;
        for (int j = 0; j < 4; j++) d[8*(60+j) +: 8] = KEY_A[8*j +: 8];
        send_beat(d, 1'b0);
        cycles(3);
        check("t2_no_result_beat0", 32'(res_valid), 0);
        d = '0;
        for (int j = 0; j < 4; j++) d[8*j +: 8] = KEY_A[8*(4+j) +: 8];
        send_beat(d, 1'b1);
        cycles(1);
        check("t2_res_offset", res_offset, 60);
        check("t2_match_count", match_count, 2);
        wait_idle();

        // Three hits, ordering and in_ready low time.
        write_key(1, KEY_A);
        write_key(2, KEY_B);
        send_beat(place(place('0, 3, KEY_A), 40, KEY_B), 1'b1);
        n = 0;
        while (!in_ready && n < 20) begin n++; cycles(1); end
        check("t3_in_ready_low_cycles", 32'(n), 3);
        wait_idle();
        check("t3_match_count", match_count, 5);

        // FIFO full stall: 10 hits with res_ready low.
        d10 = '0;
        for (int i = 0; i < 5; i++) d10 = place(d10, 8 * i, KEY_A);
        res_ready = 1'b0;
        send_beat(d10, 1'b1);
        cycles(12);
        check("t4_stall_in_ready", 32'(in_ready), 0);
        check("t4_stall_count", match_count, 13);
        res_ready = 1'b1;
        wait_idle();
        check("t4_final_count", match_count, 15);

        // first_only across a stream and into the next.
        first_only = 1'b1;
        send_beat(place(place('0, 10, KEY_A), 20, KEY_A), 1'b0);
        send_beat(place('0, 5, KEY_A), 1'b0);
        send_beat(place('0, 0, KEY_A), 1'b1);
        wait_idle();
        check("t5_first_only_count", match_count, 16);
        send_beat(place('0, 30, KEY_A), 1'b1);
        wait_idle();
        check("t5_next_stream_count", match_count, 17);
        first_only = 1'b0;

        // Reset in the middle of a drain.
        res_ready = 1'b0;
        send_beat(d10, 1'b1);
        cycles(3);
        areset = 1'b1;
        #1;
        model_reset();
        check("t6_rst_res_valid", 32'(res_valid), 0);
        check("t6_rst_match_count", match_count, 0);
        check("t6_rst_in_ready", 32'(in_ready), 0);
        @(posedge fclk); #1 areset = 1'b0;
        res_ready = 1'b1;
        cycles(1);
        send_beat(d10, 1'b1);
        cycles(5);
        check("t6_replay_res_valid", 32'(res_valid), 0);
        check("t6_replay_count", match_count, 0);

        // Randomised streams against the model.
        for (int k = 0; k < NK; k++) write_key(k, rand_key());
        rand_rr = 1'b1;
        for (int s = 0; s < 40; s++) begin
            int nb;
            wait_idle();
            if ($urandom_range(0, 19) == 0) begin
                clear_keys();
                write_key($urandom_range(0, NK - 1), rand_key());
                write_key($urandom_range(0, NK - 1), rand_key());
            end
            first_only = ($urandom_range(0, 2) == 0);
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 7) == 0) write_key($urandom_range(0, NK - 1), rand_key());
                for (int i = 0; i < BB; i++) d[8*i +: 8] = 8'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0 && m_en[0])
                    d = place(d, $urandom_range(0, BB - 1), {m_key[0][7], m_key[0][6], m_key[0][5],
                              m_key[0][4], m_key[0][3], m_key[0][2], m_key[0][1], m_key[0][0]});
                send_beat(d, (b == nb - 1));
                cycles($urandom_range(0, 2));
            end
        end
        rand_rr = 1'b0;
        @(posedge fclk); #2 res_ready = 1'b1;
        wait_idle();
        check("rand_match_count", match_count, m_pushes);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
